l2_arbiter: RTL and testbench

Two-port arbiter between the L1 instruction cache and L1 data cache miss ports and the single request port of the unified L2 cache.
- Each cycle in IDLE it picks at most one pending L1 request, with round-robin on contention.
- It latches that request's address and write data and presents them to the L2 until the L2 responds.
- It routes the response back only to the granted L1.
- It sits directly upstream of the L2 cache controller; the L2's physical-memory side is unaffected.

---
 rtl/l2_arbiter.sv | 109 ++++++++++
 tb/tb_l2_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/l2_arbiter.sv
// Arbitrates the L1 I-cache and D-cache miss ports onto the single request port of the unified L2 cache.
// Latency: a request seen in IDLE reaches the L2 one cycle later, and the response passes through combinationally.
// Backpressure: each L1 holds its request until its resp pulse; requests that arrive while another is being served wait.
//
// Ports:
//   clk, rst_n                     clock (rising edge), asynchronous active-low reset
//   i_mem_read/address             I-cache line read request (held until i_mem_resp)
//   i_mem_rdata/resp               read line and one-cycle completion pulse to the I-cache
//   d_mem_read/write/address/wdata D-cache read or write-back request (held until d_mem_resp)
//   d_mem_rdata/resp               read line and one-cycle completion pulse to the D-cache
//   l2_mem_read/write/address/wdata registered request to the L2
//   l2_mem_rdata/resp              L2 read line and completion (may arrive in the request's first cycle)
module l2_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_mem_read,
    input  logic [ADDR_W-1:0] i_mem_address,
    output logic [LINE_W-1:0] i_mem_rdata,
    output logic              i_mem_resp,
    input  logic              d_mem_read,
    input  logic              d_mem_write,
    input  logic [ADDR_W-1:0] d_mem_address,
    input  logic [LINE_W-1:0] d_mem_wdata,
    output logic [LINE_W-1:0] d_mem_rdata,
    output logic              d_mem_resp,
    output logic              l2_mem_read,
    output logic              l2_mem_write,
    output logic [ADDR_W-1:0] l2_mem_address,
    output logic [LINE_W-1:0] l2_mem_wdata,
    input  logic [LINE_W-1:0] l2_mem_rdata,
    input  logic              l2_mem_resp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t state;
    logic   last_grant;   // 0 = I served last, 1 = D served last
    logic   req_i;
    logic   req_d;
    logic   grant_i;
    logic   grant_d;

    assign req_i   = i_mem_read;
    assign req_d   = d_mem_read | d_mem_write;
    // On a tie the side opposite last_grant wins; a lone requester always wins.
    assign grant_d = req_d & (~req_i | ~last_grant);
    assign grant_i = req_i & ~grant_d;

    // Read data is shared; only the resp pulse tells each L1 the line is meant for it.
    assign i_mem_rdata = l2_mem_rdata;
    assign d_mem_rdata = l2_mem_rdata;
    assign i_mem_resp  = (state == SERVE_I) & l2_mem_resp;
    assign d_mem_resp  = (state == SERVE_D) & l2_mem_resp;

    // l2_mem_read/l2_mem_write act as the latched op: set on grant, cleared on
    // resp, so they drop the cycle after resp and the L2 never sees a stale request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            last_grant     <= 1'b1;
            l2_mem_read    <= 1'b0;
            l2_mem_write   <= 1'b0;
            l2_mem_address <= '0;
            l2_mem_wdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_i) begin
                        l2_mem_address <= i_mem_address;
                        l2_mem_wdata   <= '0;
                        l2_mem_read    <= 1'b1;
                        l2_mem_write   <= 1'b0;
                        last_grant     <= 1'b0;
                        state          <= SERVE_I;
                    end else if (grant_d) begin
                        l2_mem_address <= d_mem_address;
                        l2_mem_wdata   <= d_mem_wdata;
                        // A write-back takes precedence if both op bits are set.
                        l2_mem_read    <= ~d_mem_write;
                        l2_mem_write   <= d_mem_write;
                        last_grant     <= 1'b1;
                        state          <= SERVE_D;
                    end
                end
                SERVE_I, SERVE_D: begin
                    // Requester drops mid-serve are ignored; the transaction runs to resp.
                    if (l2_mem_resp) begin
                        l2_mem_read  <= 1'b0;
                        l2_mem_write <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: begin
                    l2_mem_read  <= 1'b0;
                    l2_mem_write <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l2_arbiter.sv
module tb_l2_arbiter;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;

    logic              clk;
    logic              rst_n;
    logic              i_mem_read;
    logic [ADDR_W-1:0] i_mem_address;
    logic [LINE_W-1:0] i_mem_rdata;
    logic              i_mem_resp;
    logic              d_mem_read;
    logic              d_mem_write;
    logic [ADDR_W-1:0] d_mem_address;
    logic [LINE_W-1:0] d_mem_wdata;
    logic [LINE_W-1:0] d_mem_rdata;
    logic              d_mem_resp;
    logic              l2_mem_read;
    logic              l2_mem_write;
    logic [ADDR_W-1:0] l2_mem_address;
    logic [LINE_W-1:0] l2_mem_wdata;
    logic [LINE_W-1:0] l2_mem_rdata;
    logic              l2_mem_resp;

    typedef struct packed {
        logic              port;   // 0 = I, 1 = D
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] wdata;
    } txn_t;

    txn_t exp_q[$];
    int   n_vec;
    int   n_err;

    l2_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_mem_read     (i_mem_read),
        .i_mem_address  (i_mem_address),
        .i_mem_rdata    (i_mem_rdata),
        .i_mem_resp     (i_mem_resp),
        .d_mem_read     (d_mem_read),
        .d_mem_write    (d_mem_write),
        .d_mem_address  (d_mem_address),
        .d_mem_wdata    (d_mem_wdata),
        .d_mem_rdata    (d_mem_rdata),
        .d_mem_resp     (d_mem_resp),
        .l2_mem_read    (l2_mem_read),
        .l2_mem_write   (l2_mem_write),
        .l2_mem_address (l2_mem_address),
        .l2_mem_wdata   (l2_mem_wdata),
        .l2_mem_rdata   (l2_mem_rdata),
        .l2_mem_resp    (l2_mem_resp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running want done");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Plays the L2: waits for a request, compares it with the scoreboard head,
    // holds it for lat cycles, then responds and checks the routed resp pulse.
    task automatic serve(input int lat, input logic [LINE_W-1:0] rd, input bit drop,
                         input bit chg_addr, input logic [ADDR_W-1:0] new_addr);
        int   waited;
        bit   seen;
        txn_t e;
        waited = 0;
        seen   = 1'b0;
        while (!seen && waited < 20) begin
            @(negedge clk); #1;
            waited++;
            if (l2_mem_read || l2_mem_write) seen = 1'b1;
        end
        chk("l2_req_seen", LINE_W'(seen), LINE_W'(1));
        if (!seen) return;
        chk("req_latency", LINE_W'(waited), LINE_W'(1));
        if (exp_q.size() == 0) begin
            chk("sb_nonempty", LINE_W'(0), LINE_W'(1));
            return;
        end
        e = exp_q.pop_front();
        for (int k = 0; k <= lat; k++) begin
            if (k > 0) begin
                @(negedge clk); #1;
            end
            chk("l2_read",  LINE_W'(l2_mem_read),    LINE_W'(!e.wr));
            chk("l2_write", LINE_W'(l2_mem_write),   LINE_W'(e.wr));
            chk("l2_addr",  LINE_W'(l2_mem_address), LINE_W'(e.addr));
            if (e.wr) chk("l2_wdata", l2_mem_wdata, e.wdata);
            if (chg_addr && k == 1) d_mem_address = new_addr;
            if (k == lat) begin
                l2_mem_rdata = rd;
                l2_mem_resp  = 1'b1;
                #1;
                chk("i_resp", LINE_W'(i_mem_resp), LINE_W'(!e.port));
                chk("d_resp", LINE_W'(d_mem_resp), LINE_W'(e.port));
                chk(e.port ? "d_rdata" : "i_rdata", e.port ? d_mem_rdata : i_mem_rdata, rd);
            end else begin
                chk("resp_early", LINE_W'({i_mem_resp, d_mem_resp}), LINE_W'(0));
            end
        end
        @(negedge clk);
        l2_mem_resp = 1'b0;
        if (drop) begin
            if (e.port) begin
                d_mem_read  = 1'b0;
                d_mem_write = 1'b0;
            end else begin
                i_mem_read = 1'b0;
            end
        end
        #1;
        chk("bubble_req", LINE_W'({l2_mem_read, l2_mem_write}), LINE_W'(0));
        chk("bubble_resp", LINE_W'({i_mem_resp, d_mem_resp}), LINE_W'(0));
    endtask

    function automatic txn_t mk(input logic port, input logic wr, input logic [ADDR_W-1:0] a,
                                input logic [LINE_W-1:0] wd);
        txn_t t;
        t.port  = port;
        t.wr    = wr;
        t.addr  = a;
        t.wdata = wd;
        return t;
    endfunction

    logic [LINE_W-1:0] pat_a5;
    logic [LINE_W-1:0] pat_3c;

    initial begin
        n_vec = 0;
        n_err = 0;
        pat_a5 = {32{8'hA5}};
        pat_3c = {32{8'h3C}};
        rst_n = 1'b0;
        i_mem_read = 1'b0; i_mem_address = '0;
        d_mem_read = 1'b0; d_mem_write = 1'b0; d_mem_address = '0; d_mem_wdata = '0;
        l2_mem_rdata = {8{32'hDEAD_BEEF}};
        l2_mem_resp = 1'b0;

        // Reset state
        #3;
        chk("rst_l2_req",  LINE_W'({l2_mem_read, l2_mem_write}), LINE_W'(0));
        chk("rst_resp",    LINE_W'({i_mem_resp, d_mem_resp}), LINE_W'(0));
        chk("rst_addr",    LINE_W'(l2_mem_address), LINE_W'(0));
        chk("rst_wdata",   l2_mem_wdata, LINE_W'(0));
        chk("rst_i_rdata", i_mem_rdata, {8{32'hDEAD_BEEF}});
        chk("rst_d_rdata", d_mem_rdata, {8{32'hDEAD_BEEF}});
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // I-only read, L2 hit
        @(negedge clk);
        i_mem_read = 1'b1; i_mem_address = 32'h0000_1000;
        exp_q.push_back(mk(1'b0, 1'b0, 32'h0000_1000, '0));
        #1;
        chk("no_comb_path", LINE_W'(l2_mem_read), LINE_W'(0));
        serve(0, {8{32'h1111_2222}}, 1'b1, 1'b0, '0);

        // D write-back, 10-cycle miss
        @(negedge clk);
        d_mem_write = 1'b1; d_mem_address = 32'h0000_2040; d_mem_wdata = pat_a5;
        exp_q.push_back(mk(1'b1, 1'b1, 32'h0000_2040, pat_a5));
        serve(10, '0, 1'b1, 1'b0, '0);

        // Read and write both set on D: the write wins
        @(negedge clk);
        d_mem_read = 1'b1; d_mem_write = 1'b1; d_mem_address = 32'h0000_3080; d_mem_wdata = pat_3c;
        exp_q.push_back(mk(1'b1, 1'b1, 32'h0000_3080, pat_3c));
        serve(1, '0, 1'b1, 1'b0, '0);

        // Contention with both sides held continuously: I, D, I, D
        @(negedge clk);
        i_mem_read = 1'b1; i_mem_address = 32'h0000_4000;
        d_mem_read = 1'b1; d_mem_address = 32'h0000_5000;
        for (int r = 0; r < 2; r++) begin
            exp_q.push_back(mk(1'b0, 1'b0, 32'h0000_4000, '0));
            exp_q.push_back(mk(1'b1, 1'b0, 32'h0000_5000, '0));
        end
        for (int r = 0; r < 4; r++) serve(r % 3, {8{r[31:0] + 32'h100}}, 1'b0, 1'b0, '0);
        i_mem_read = 1'b0;
        d_mem_read = 1'b0;

        // Address latched through SERVE_D despite the input changing
        @(negedge clk);
        d_mem_read = 1'b1; d_mem_address = 32'h0000_0100;
        exp_q.push_back(mk(1'b1, 1'b0, 32'h0000_0100, '0));
        serve(5, {8{32'h0BAD_F00D}}, 1'b1, 1'b1, 32'h0000_0200);

        // Reset in the middle of a D miss
        @(negedge clk);
        d_mem_read = 1'b1; d_mem_address = 32'h0000_0300;
        @(negedge clk); #1;
        chk("pre_rst_read", LINE_W'(l2_mem_read), LINE_W'(1));
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rst_async_req", LINE_W'({l2_mem_read, l2_mem_write}), LINE_W'(0));
        chk("rst_async_addr", LINE_W'(l2_mem_address), LINE_W'(0));
        d_mem_read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        l2_mem_resp = 1'b1;
        #1;
        chk("late_resp_d", LINE_W'(d_mem_resp), LINE_W'(0));
        chk("late_resp_i", LINE_W'(i_mem_resp), LINE_W'(0));
        @(negedge clk); #1;
        chk("late_resp_idle", LINE_W'({l2_mem_read, l2_mem_write, d_mem_resp}), LINE_W'(0));
        l2_mem_resp = 1'b0;
        i_mem_read = 1'b1; i_mem_address = 32'h0000_6000;
        d_mem_read = 1'b1; d_mem_address = 32'h0000_7000;
        exp_q.push_back(mk(1'b0, 1'b0, 32'h0000_6000, '0));
        exp_q.push_back(mk(1'b1, 1'b0, 32'h0000_7000, '0));
        serve(0, {8{32'h6666_6666}}, 1'b1, 1'b0, '0);
        serve(2, {8{32'h7777_7777}}, 1'b1, 1'b0, '0);

        chk("sb_drained", LINE_W'(exp_q.size()), LINE_W'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
